// File: rtl/ct_split_pkg.sv
// Shared definitions for the ct splitter: packet framing state and sizing helper.
package ct_split_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,  // awaiting start of packet
    ST_PKT  = 1'b1   // mid-packet, destination mask locked
  } pkt_state_e;

  function automatic int clogb2(input int value);
    int v;
    v = (value > 1) ? value - 1 : 1;
    clogb2 = 0;
    while (v > 0) begin
      clogb2++;
      v = v >> 1;
    end
  endfunction

endpackage

// File: rtl/ct_split_if.sv
// Beat bus for the 1-to-NO splitter: one valid/ready/eop input, NO replicated outputs.
interface ct_split_if #(
  parameter int NO    = 2,
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0]         i_data;
  logic                     i_valid;
  logic                     o_ready;
  logic                     i_eop;
  logic [NO-1:0]            i_mask;
  logic [NO-1:0][WIDTH-1:0] o_data;
  logic [NO-1:0]            o_valid;
  logic [NO-1:0]            o_eop;
  logic [NO-1:0]            i_ready;

  modport slave (
    input  i_data, i_valid, i_eop, i_mask, i_ready,
    output o_ready, o_data, o_valid, o_eop
  );

  modport master (
    output i_data, i_valid, i_eop, i_mask, i_ready,
    input  o_ready, o_data, o_valid, o_eop
  );
endinterface

// File: rtl/ct_split_track.sv
// Per-output acceptance tracker: offers a beat to every masked output that has not
// taken it yet and retires the beat once all masked outputs are covered.
module ct_split_track #(
  parameter int NO = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid,
  input  logic [NO-1:0] mask,
  input  logic [NO-1:0] ready,
  output logic [NO-1:0] offer,
  output logic          retire,
  output logic          xfer
);

  logic [NO-1:0] done;
  logic [NO-1:0] accept;
  logic [NO-1:0] clear;

  for (genvar k = 0; k < NO; k++) begin : g_lane
    assign offer[k]  = valid & mask[k] & ~done[k];
    assign accept[k] = offer[k] & ready[k];
    // Output k no longer blocks the beat if served, unselected, or ready now.
    assign clear[k]  = done[k] | ~mask[k] | ready[k];
  end

  assign retire = &clear;
  assign xfer   = valid & retire;

  // done survives i_valid dropping so a resumed beat is never re-offered.
  always_ff @(posedge clk) begin
    if (reset)     done <= '0;
    else if (xfer) done <= '0;
    else           done <= done | accept;
  end

endmodule

// File: rtl/ct_split.sv
// 1-to-NO packet splitter/broadcaster: locks the destination mask at SOP and
// retires each beat only after every selected output has accepted it once.
module ct_split
  import ct_split_pkg::*;
#(
  parameter int NO    = 2,
  parameter int WIDTH = 1
) (
  input  logic     clk,
  input  logic     reset,
  ct_split_if.slave bus
);

  pkt_state_e       state;
  logic [NO-1:0]    pkt_mask;
  logic [NO-1:0]    eff_mask;
  logic [WIDTH-1:0] beat_data;
  logic             xfer;

  assign eff_mask  = (state == ST_PKT) ? pkt_mask : bus.i_mask;
  assign beat_data = bus.i_data;

  ct_split_track #(.NO(NO)) u_track (
    .clk    (clk),
    .reset  (reset),
    .valid  (bus.i_valid),
    .mask   (eff_mask),
    .ready  (bus.i_ready),
    .offer  (bus.o_valid),
    .retire (bus.o_ready),
    .xfer   (xfer)
  );

  for (genvar k = 0; k < NO; k++) begin : g_rep
    assign bus.o_data[k] = beat_data;
    assign bus.o_eop[k]  = bus.i_eop;
  end

  // Single-beat packets return straight to IDLE; the mask is only captured at SOP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      pkt_mask <= '0;
    end else if (xfer) begin
      if (state == ST_IDLE) pkt_mask <= bus.i_mask;
      state <= bus.i_eop ? ST_IDLE : ST_PKT;
    end
  end

endmodule

// File: tb/tb_ct_split.sv
// Bench for ct_split (NO=4, WIDTH=8): directed scenarios plus randomized traffic
// against a set-based delivery model with per-output accept counting.
module tb_ct_split;
  localparam int NO    = 4;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  ct_split_if #(.NO(NO), .WIDTH(WIDTH)) bus ();

  ct_split #(.NO(NO), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic drive(input logic v, input logic [7:0] d, input logic e,
                       input logic [3:0] m, input logic [3:0] r);
    bus.i_valid = v;
    bus.i_data  = d;
    bus.i_eop   = e;
    bus.i_mask  = m;
    bus.i_ready = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 4'h0, 4'h0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    drive(1'b0, 8'h00, 1'b0, 4'b0110, 4'b0010);
    n_tests++; if (bus.o_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_valid got %b want %b", bus.o_valid, 4'b0000); end
    n_tests++; if (bus.o_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_blocked got %b want 0", bus.o_ready); end
    drive(1'b0, 8'h00, 1'b0, 4'b0110, 4'b0110);
    n_tests++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_open got %b want 1", bus.o_ready); end
  endtask

  task automatic test_single();
    drive(1'b1, 8'hA5, 1'b1, 4'b0100, 4'b1111);
    n_tests++; if (bus.o_valid !== 4'b0100) begin n_fail++; $display("FAIL single_valid got %b want %b", bus.o_valid, 4'b0100); end
    n_tests++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready got %b want 1", bus.o_ready); end
    n_tests++; if (bus.o_data[2] !== 8'hA5 || bus.o_eop[2] !== 1'b1) begin n_fail++; $display("FAIL single_data got %h/%b want a5/1", bus.o_data[2], bus.o_eop[2]); end
    tick();
    // in_pkt stayed 0: the next beat is a SOP with the new mask
    drive(1'b1, 8'h5A, 1'b1, 4'b0001, 4'b0000);
    n_tests++; if (bus.o_valid !== 4'b0001) begin n_fail++; $display("FAIL single_next_sop got %b want %b", bus.o_valid, 4'b0001); end
    n_tests++; if (bus.o_ready !== 1'b0) begin n_fail++; $display("FAIL demux_blocked got %b want 0", bus.o_ready); end
    drive(1'b1, 8'h5A, 1'b1, 4'b0001, 4'b0001);
    n_tests++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL demux_ready got %b want 1", bus.o_ready); end
    tick();
    drive(1'b0, 8'h00, 1'b0, 4'h0, 4'h0);
  endtask

  task automatic test_broadcast();
    logic [3:0] rdy [3]  = '{4'b0011, 4'b0100, 4'b1000};
    logic [3:0] expv [3] = '{4'b1111, 4'b1100, 4'b1000};
    logic       expr [3] = '{1'b0, 1'b0, 1'b1};
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 8'h3C, 1'b1, 4'b1111, rdy[c]);
      n_tests++; if (bus.o_valid !== expv[c]) begin n_fail++; $display("FAIL bcast_valid_c%0d got %b want %b", c, bus.o_valid, expv[c]); end
      n_tests++; if (bus.o_ready !== expr[c]) begin n_fail++; $display("FAIL bcast_ready_c%0d got %b want %b", c, bus.o_ready, expr[c]); end
      tick();
    end
    // beat retired: a fresh broadcast is offered to all outputs again
    drive(1'b1, 8'h3D, 1'b1, 4'b1111, 4'b0000);
    n_tests++; if (bus.o_valid !== 4'b1111) begin n_fail++; $display("FAIL bcast_cleared got %b want 1111", bus.o_valid); end
    drive(1'b1, 8'h3D, 1'b1, 4'b1111, 4'b1111);
    tick();
    drive(1'b0, 8'h00, 1'b0, 4'h0, 4'h0);
  endtask

  task automatic test_mask_lock();
    drive(1'b1, 8'h01, 1'b0, 4'b0010, 4'b1111);
    n_tests++; if (bus.o_valid !== 4'b0010 || bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL lock_b1 got %b/%b want 0010/1", bus.o_valid, bus.o_ready); end
    tick();
    drive(1'b1, 8'h02, 1'b0, 4'b0001, 4'b1111);
    n_tests++; if (bus.o_valid !== 4'b0010) begin n_fail++; $display("FAIL lock_b2 got %b want 0010", bus.o_valid); end
    tick();
    drive(1'b1, 8'h03, 1'b1, 4'b0001, 4'b1101);
    n_tests++; if (bus.o_valid !== 4'b0010 || bus.o_ready !== 1'b0) begin n_fail++; $display("FAIL lock_b3_stall got %b/%b want 0010/0", bus.o_valid, bus.o_ready); end
    drive(1'b1, 8'h03, 1'b1, 4'b0001, 4'b1111);
    n_tests++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL lock_b3_ready got %b want 1", bus.o_ready); end
    tick();
    drive(1'b1, 8'h04, 1'b1, 4'b0001, 4'b0000);
    n_tests++; if (bus.o_valid !== 4'b0001) begin n_fail++; $display("FAIL lock_next_sop got %b want 0001", bus.o_valid); end
    drive(1'b1, 8'h04, 1'b1, 4'b0001, 4'b0001);
    tick();
    drive(1'b0, 8'h00, 1'b0, 4'h0, 4'h0);
  endtask

  task automatic test_zero_mask();
    drive(1'b1, 8'h10, 1'b0, 4'b0000, 4'b0000);
    n_tests++; if (bus.o_valid !== 4'b0000 || bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL drop_b1 got %b/%b want 0000/1", bus.o_valid, bus.o_ready); end
    tick();
    drive(1'b1, 8'h11, 1'b1, 4'b1000, 4'b0000);
    n_tests++; if (bus.o_valid !== 4'b0000 || bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL drop_b2 got %b/%b want 0000/1", bus.o_valid, bus.o_ready); end
    tick();
    drive(1'b1, 8'h12, 1'b1, 4'b1000, 4'b0000);
    n_tests++; if (bus.o_valid !== 4'b1000 || bus.o_ready !== 1'b0) begin n_fail++; $display("FAIL drop_next got %b/%b want 1000/0", bus.o_valid, bus.o_ready); end
    drive(1'b1, 8'h12, 1'b1, 4'b1000, 4'b1000);
    tick();
    drive(1'b0, 8'h00, 1'b0, 4'h0, 4'h0);
  endtask

  task automatic test_partial();
    drive(1'b1, 8'h20, 1'b1, 4'b0011, 4'b0001);
    n_tests++; if (bus.o_valid !== 4'b0011 || bus.o_ready !== 1'b0) begin n_fail++; $display("FAIL part_first got %b/%b want 0011/0", bus.o_valid, bus.o_ready); end
    tick();
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 8'h20, 1'b1, 4'b0011, 4'b0000);
      n_tests++; if (bus.o_valid !== 4'b0000) begin n_fail++; $display("FAIL part_gap%0d got %b want 0000", c, bus.o_valid); end
      tick();
    end
    drive(1'b1, 8'h20, 1'b1, 4'b0011, 4'b0000);
    n_tests++; if (bus.o_valid !== 4'b0010) begin n_fail++; $display("FAIL part_resume got %b want 0010", bus.o_valid); end
    drive(1'b1, 8'h20, 1'b1, 4'b0011, 4'b0010);
    n_tests++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL part_retire got %b want 1", bus.o_ready); end
    tick();
    drive(1'b0, 8'h00, 1'b0, 4'h0, 4'h0);
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 8'h30, 1'b0, 4'b0110, 4'b1111);
    tick();
    drive(1'b1, 8'h31, 1'b0, 4'b1111, 4'b0010);
    n_tests++; if (bus.o_valid !== 4'b0110) begin n_fail++; $display("FAIL rmid_locked got %b want 0110", bus.o_valid); end
    tick();
    reset = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 4'h0, 4'h0);
    tick();
    reset = 1'b0;
    drive(1'b1, 8'h32, 1'b1, 4'b1001, 4'b0000);
    n_tests++; if (bus.o_valid !== 4'b1001 || bus.o_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_sop got %b/%b want 1001/0", bus.o_valid, bus.o_ready); end
    drive(1'b1, 8'h32, 1'b1, 4'b1001, 4'b1001);
    n_tests++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_retire got %b want 1", bus.o_ready); end
    tick();
    drive(1'b0, 8'h00, 1'b0, 4'h0, 4'h0);
  endtask

  // Model: a beat is owed to every destination of its packet; it retires once
  // each owed destination has taken it, and each destination takes it exactly once.
  task automatic test_random();
    logic       mid_pkt;
    logic [3:0] locked, served, dest, owed, exp_v, r, m_in;
    logic       exp_r, v, e, need;
    logic [7:0] d;
    logic [3:0] pm, cnt_ok;
    int         cnt [4];
    int         left, retired;
    do_reset();
    mid_pkt = 1'b0; locked = '0; served = '0; need = 1'b1; left = 0; retired = 0;
    pm = '0; d = '0; e = 1'b0;
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    for (int c = 0; c < 3000; c++) begin
      if (need) begin
        if (left == 0) begin
          left = $urandom_range(1, 4);
          case ($urandom_range(0, 3))
            0:       pm = 4'h0;
            1:       pm = 4'(1 << $urandom_range(0, 3));
            default: pm = 4'($urandom);
          endcase
        end
        d = 8'($urandom);
        e = (left == 1);
        left--;
        need = 1'b0;
      end
      v    = ($urandom_range(0, 3) != 0);
      r    = 4'($urandom);
      m_in = mid_pkt ? 4'($urandom) : pm;
      drive(v, d, e, m_in, r);
      dest  = mid_pkt ? locked : pm;
      owed  = dest & ~served;
      exp_v = v ? owed : 4'h0;
      exp_r = ((owed & ~r) == 4'h0);
      n_tests++; if (bus.o_valid !== exp_v) begin n_fail++; $display("FAIL rnd_valid c%0d got %b want %b", c, bus.o_valid, exp_v); end
      n_tests++; if (bus.o_ready !== exp_r) begin n_fail++; $display("FAIL rnd_ready c%0d got %b want %b", c, bus.o_ready, exp_r); end
      for (int k = 0; k < 4; k++) begin
        if (exp_v[k]) begin
          n_tests++; if (bus.o_data[k] !== d || bus.o_eop[k] !== e) begin n_fail++; $display("FAIL rnd_data c%0d o%0d got %h/%b want %h/%b", c, k, bus.o_data[k], bus.o_eop[k], d, e); end
        end
        if (bus.o_valid[k] === 1'b1 && r[k]) cnt[k]++;
      end
      if (v && exp_r) begin
        for (int k = 0; k < 4; k++) cnt_ok[k] = (cnt[k] == (dest[k] ? 1 : 0));
        n_tests++; if (cnt_ok !== 4'hF) begin n_fail++; $display("FAIL rnd_once c%0d counts %0d %0d %0d %0d dest %b", c, cnt[0], cnt[1], cnt[2], cnt[3], dest); end
        for (int k = 0; k < 4; k++) cnt[k] = 0;
        served  = '0;
        locked  = dest;
        mid_pkt = !e;
        need    = 1'b1;
        retired++;
      end else if (v) begin
        served = served | (owed & r);
      end
      tick();
    end
    n_tests++; if (retired < 200) begin n_fail++; $display("FAIL rnd_progress got %0d beats want >=200", retired); end
    drive(1'b0, 8'h00, 1'b0, 4'h0, 4'h0);
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_single();
    test_broadcast();
    test_mask_lock();
    test_zero_mask();
    test_partial();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
